// File: rtl/ccu_ctrl_snoop_collector.sv
// Snoop collector ahead of the CCU snoop unit: fans an AC snoop out to every
// non-initiating port, gathers CR responses, and hands a summary to the snoop unit or memory path.
module ccu_ctrl_snoop_collector #(
    parameter int unsigned NoMstPorts = 4,
    parameter type mst_req_t = struct packed {
        struct packed {
            logic [31:0] addr;
            logic [3:0]  snoop;
            logic [2:0]  prot;
        } ar;
    },
    parameter type snoop_ac_t = struct packed {
        logic [31:0] addr;
        logic [3:0]  snoop;
        logic [2:0]  prot;
    },
    parameter type snoop_cr_t = logic [4:0],
    localparam int unsigned MstIdxBits = $clog2(NoMstPorts)
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  mst_req_t                          req_i,
    input  logic [MstIdxBits-1:0]             req_initiator_i,
    input  logic                              req_valid_i,
    output logic                              req_ready_o,
    output snoop_ac_t [NoMstPorts-1:0]        ac_o,
    output logic [NoMstPorts-1:0]             ac_valid_o,
    input  logic [NoMstPorts-1:0]             ac_ready_i,
    input  snoop_cr_t [NoMstPorts-1:0]        cr_i,
    input  logic [NoMstPorts-1:0]             cr_valid_i,
    output logic [NoMstPorts-1:0]             cr_ready_o,
    output mst_req_t                          ccu_req_holder_o,
    output logic                              su_valid_o,
    input  logic                              su_ready_i,
    output logic                              su_op_o,
    output logic                              shared_o,
    output logic                              dirty_o,
    output logic [NoMstPorts-1:0]             data_available_o,
    output logic [MstIdxBits-1:0]             first_responder_o,
    output logic                              mem_valid_o,
    input  logic                              mem_ready_i
);

    typedef enum logic [2:0] {IDLE, SNOOP, DECIDE, SEND_SU, SEND_MEM} state_e;
    // su_op_o encoding: 0 = READ_SNP_DATA, 1 = SEND_INVALID_ACK_R
    typedef enum logic {READ_SNP_DATA = 1'b0, SEND_INVALID_ACK_R = 1'b1} su_op_e;

    state_e                         state_q, state_d;
    mst_req_t                       holder_q, holder_d;
    logic [NoMstPorts-1:0]          mask_q, mask_d;
    logic [NoMstPorts-1:0]          ac_done_q, ac_done_d;
    logic [NoMstPorts-1:0]          cr_done_q, cr_done_d;
    logic [NoMstPorts-1:0][4:0]     resp_q, resp_d;
    logic [NoMstPorts-1:0]          da_q, da_d;
    logic                           shared_q, shared_d;
    logic                           dirty_q, dirty_d;
    logic [MstIdxBits-1:0]          fr_q, fr_d;
    su_op_e                         su_op_q, su_op_d;
    logic                           req_ready_q, req_ready_d;
    logic                           su_valid_q, su_valid_d;
    logic                           mem_valid_q, mem_valid_d;

    logic [NoMstPorts-1:0]          ac_hs;
    logic [NoMstPorts-1:0]          cr_hs;
    logic                           found;
    logic                           invalidating;

    always_comb begin
        state_d      = state_q;
        holder_d     = holder_q;
        mask_d       = mask_q;
        ac_done_d    = ac_done_q;
        cr_done_d    = cr_done_q;
        resp_d       = resp_q;
        da_d         = da_q;
        shared_d     = shared_q;
        dirty_d      = dirty_q;
        fr_d         = fr_q;
        su_op_d      = su_op_q;
        ac_valid_o   = '0;
        cr_ready_o   = '0;
        ac_hs        = '0;
        cr_hs        = '0;
        found        = 1'b0;
        invalidating = 1'b0;
        ac_o         = '0;

        for (int unsigned i = 0; i < NoMstPorts; i++) begin
            ac_o[i].addr  = holder_q.ar.addr;
            ac_o[i].snoop = holder_q.ar.snoop;
            ac_o[i].prot  = holder_q.ar.prot;
        end

        case (state_q)
            IDLE: begin
                if (req_ready_q && req_valid_i) begin
                    holder_d                  = req_i;
                    mask_d                    = '1;
                    mask_d[req_initiator_i]   = 1'b0;
                    ac_done_d                 = '0;
                    cr_done_d                 = '0;
                    resp_d                    = '0;
                    state_d                   = SNOOP;
                end
            end
            SNOOP: begin
                // A CR may be accepted in the same cycle as its port's AC handshake.
                for (int unsigned i = 0; i < NoMstPorts; i++) begin
                    ac_valid_o[i] = mask_q[i] & ~ac_done_q[i];
                    ac_hs[i]      = ac_valid_o[i] & ac_ready_i[i];
                    cr_ready_o[i] = mask_q[i] & ~cr_done_q[i] & (ac_done_q[i] | ac_hs[i]);
                    cr_hs[i]      = cr_ready_o[i] & cr_valid_i[i];
                    if (cr_hs[i]) begin
                        resp_d[i] = cr_i[i];
                    end
                end
                ac_done_d = ac_done_q | ac_hs;
                cr_done_d = cr_done_q | cr_hs;
                if ((cr_done_d & mask_q) == mask_q) begin
                    state_d = DECIDE;
                end
            end
            DECIDE: begin
                shared_d = 1'b0;
                dirty_d  = 1'b0;
                fr_d     = '0;
                for (int unsigned i = 0; i < NoMstPorts; i++) begin
                    da_d[i] = resp_q[i][0] & mask_q[i];
                    // Error responses are folded into the shared indication.
                    shared_d = shared_d | (mask_q[i] & (resp_q[i][3] | resp_q[i][1]));
                    dirty_d  = dirty_d | (mask_q[i] & resp_q[i][2]);
                    if (da_d[i] && !found) begin
                        fr_d  = MstIdxBits'(i);
                        found = 1'b1;
                    end
                end
                invalidating = (holder_q.ar.snoop == 4'b1001) || (holder_q.ar.snoop == 4'b1101);
                if (invalidating) begin
                    su_op_d = SEND_INVALID_ACK_R;
                    state_d = SEND_SU;
                end else if (da_d != '0) begin
                    su_op_d = READ_SNP_DATA;
                    state_d = SEND_SU;
                end else begin
                    su_op_d = READ_SNP_DATA;
                    state_d = SEND_MEM;
                end
            end
            SEND_SU: begin
                if (su_ready_i) begin
                    state_d = IDLE;
                end
            end
            SEND_MEM: begin
                if (mem_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        req_ready_d = (state_d == IDLE);
        su_valid_d  = (state_d == SEND_SU);
        mem_valid_d = (state_d == SEND_MEM);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            holder_q    <= '0;
            mask_q      <= '0;
            ac_done_q   <= '0;
            cr_done_q   <= '0;
            resp_q      <= '0;
            da_q        <= '0;
            shared_q    <= 1'b0;
            dirty_q     <= 1'b0;
            fr_q        <= '0;
            su_op_q     <= READ_SNP_DATA;
            req_ready_q <= 1'b0;
            su_valid_q  <= 1'b0;
            mem_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            holder_q    <= holder_d;
            mask_q      <= mask_d;
            ac_done_q   <= ac_done_d;
            cr_done_q   <= cr_done_d;
            resp_q      <= resp_d;
            da_q        <= da_d;
            shared_q    <= shared_d;
            dirty_q     <= dirty_d;
            fr_q        <= fr_d;
            su_op_q     <= su_op_d;
            req_ready_q <= req_ready_d;
            su_valid_q  <= su_valid_d;
            mem_valid_q <= mem_valid_d;
        end
    end

    assign req_ready_o       = req_ready_q;
    assign su_valid_o        = su_valid_q;
    assign mem_valid_o       = mem_valid_q;
    assign su_op_o           = su_op_q;
    assign shared_o          = shared_q;
    assign dirty_o           = dirty_q;
    assign data_available_o  = da_q;
    assign first_responder_o = fr_q;
    assign ccu_req_holder_o  = holder_q;

endmodule

// File: tb/tb_ccu_ctrl_snoop_collector.sv
// Randomised bench for ccu_ctrl_snoop_collector; expected behaviour comes from a
// transaction-level model of the snoop/collect/decide rules.
module tb_ccu_ctrl_snoop_collector;

    localparam int N = 4;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  snoop;
        logic [2:0]  prot;
    } ac_t;

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] addr;
        logic [3:0]  snoop;
        logic [2:0]  prot;
    } ar_t;

    typedef struct packed {
        ar_t ar;
    } req_t;

    typedef struct {
        int         init;
        logic [3:0] snoop;
        logic [31:0] addr;
        logic [2:0] prot;
        logic [3:0] id;
        logic [4:0] cr [N];
        int         ac_dly [N];
        int         cr_dly [N];
        int         out_dly;
        bit         pend;
        bit         noise;
        int         abort_at;
    } txn_t;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    req_t                 req_i = '0;
    logic [1:0]           req_init = '0;
    logic                 req_valid = 1'b0;
    logic                 req_ready_o;
    ac_t [N-1:0]          ac_o;
    logic [N-1:0]         ac_valid_o;
    logic [N-1:0]         ac_ready = '0;
    logic [N-1:0][4:0]    cr_i = '0;
    logic [N-1:0]         cr_valid = '0;
    logic [N-1:0]         cr_ready_o;
    req_t                 holder_o;
    logic                 su_valid_o;
    logic                 su_ready = 1'b0;
    logic                 su_op_o;
    logic                 shared_o;
    logic                 dirty_o;
    logic [N-1:0]         da_o;
    logic [1:0]           fr_o;
    logic                 mem_valid_o;
    logic                 mem_ready = 1'b0;

    int checks = 0;
    int errors = 0;

    logic [3:0] obs_da;
    logic [1:0] obs_fr;
    logic       obs_sh, obs_dr, obs_op, obs_su, obs_mem;
    logic [3:0] obs_acv_or;
    int         obs_out_cycles;

    ccu_ctrl_snoop_collector #(
        .NoMstPorts (N),
        .mst_req_t  (req_t),
        .snoop_ac_t (ac_t),
        .snoop_cr_t (logic [4:0])
    ) dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .req_i             (req_i),
        .req_initiator_i   (req_init),
        .req_valid_i       (req_valid),
        .req_ready_o       (req_ready_o),
        .ac_o              (ac_o),
        .ac_valid_o        (ac_valid_o),
        .ac_ready_i        (ac_ready),
        .cr_i              (cr_i),
        .cr_valid_i        (cr_valid),
        .cr_ready_o        (cr_ready_o),
        .ccu_req_holder_o  (holder_o),
        .su_valid_o        (su_valid_o),
        .su_ready_i        (su_ready),
        .su_op_o           (su_op_o),
        .shared_o          (shared_o),
        .dirty_o           (dirty_o),
        .data_available_o  (da_o),
        .first_responder_o (fr_o),
        .mem_valid_o       (mem_valid_o),
        .mem_ready_i       (mem_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Reference: what the snoop unit must be told, given the request and the CR set.
    function automatic void model(input txn_t t, output logic [3:0] da, output logic sh,
                                  output logic dr, output logic [1:0] fr,
                                  output logic to_su, output logic op);
        bit inval;
        bit got;
        da = '0; sh = 1'b0; dr = 1'b0; fr = '0; got = 0;
        for (int p = 0; p < N; p++) begin
            if (p != t.init) begin
                if (t.cr[p][0]) da[p] = 1'b1;
                if (t.cr[p][3] || t.cr[p][1]) sh = 1'b1;
                if (t.cr[p][2]) dr = 1'b1;
                if (t.cr[p][0] && !got) begin
                    fr  = 2'(p);
                    got = 1;
                end
            end
        end
        inval = (t.snoop == 4'd9) || (t.snoop == 4'd13);
        to_su = inval || (da != 0);
        op    = inval;
    endfunction

    function automatic txn_t base_txn(input int init, input logic [3:0] snoop);
        txn_t t;
        t.init = init; t.snoop = snoop;
        t.addr = 32'h1000_0040; t.prot = 3'b010; t.id = 4'h5;
        for (int p = 0; p < N; p++) begin
            t.cr[p] = '0; t.ac_dly[p] = 0; t.cr_dly[p] = 0;
        end
        t.out_dly = 0; t.pend = 0; t.noise = 0; t.abort_at = -1;
        return t;
    endfunction

    task automatic check_reset_values();
        chk("rst_req_ready", 64'(req_ready_o), 64'd0);
        chk("rst_ac_valid", 64'(ac_valid_o), 64'd0);
        chk("rst_cr_ready", 64'(cr_ready_o), 64'd0);
        chk("rst_su_valid", 64'(su_valid_o), 64'd0);
        chk("rst_mem_valid", 64'(mem_valid_o), 64'd0);
        chk("rst_holder", 64'(holder_o), 64'd0);
        chk("rst_summary", 64'({shared_o, dirty_o, da_o, fr_o}), 64'd0);
    endtask

    task automatic run_txn(input txn_t t);
        logic [3:0] mask, acd, crd, exp_acv, hs, exp_crr, crv, acr;
        logic [3:0] e_da;
        logic       e_sh, e_dr, e_su, e_op;
        logic [1:0] e_fr;
        int         hs_cyc [N];
        int         c, k;
        bit         done;
        req_t       r;
        ac_t        exp_ac;

        r = '0;
        r.ar.id = t.id; r.ar.addr = t.addr; r.ar.snoop = t.snoop; r.ar.prot = t.prot;
        exp_ac.addr = t.addr; exp_ac.snoop = t.snoop; exp_ac.prot = t.prot;
        mask = 4'hF;
        mask[t.init] = 1'b0;
        model(t, e_da, e_sh, e_dr, e_fr, e_su, e_op);
        for (int p = 0; p < N; p++) hs_cyc[p] = 0;
        obs_acv_or = '0;

        @(negedge clk);
        req_i = r; req_init = 2'(t.init); req_valid = 1'b1;
        ac_ready = '0; cr_valid = '0; su_ready = 1'b0; mem_ready = 1'b0;
        #1;
        chk("req_ready_idle", 64'(req_ready_o), 64'd1);
        chk("ac_valid_idle", 64'(ac_valid_o), 64'd0);

        @(negedge clk);
        req_valid = 1'b0;
        req_i = req_t'({$urandom, $urandom});
        req_init = 2'($urandom);
        acd = '0; crd = '0; c = 0; done = 0;
        while (!done) begin
            exp_acv = mask & ~acd;
            for (int p = 0; p < N; p++)
                acr[p] = (c >= t.ac_dly[p]) || (t.noise && $urandom_range(0, 3) == 0);
            hs = exp_acv & acr;
            exp_crr = mask & ~crd & (acd | hs);
            for (int p = 0; p < N; p++)
                crv[p] = !crd[p] && ((acd[p] && c >= hs_cyc[p] + t.cr_dly[p]) ||
                                     (hs[p] && t.cr_dly[p] == 0) ||
                                     (t.noise && $urandom_range(0, 3) == 0));
            ac_ready = acr;
            cr_valid = crv;
            for (int p = 0; p < N; p++)
                cr_i[p] = (crv[p] && exp_crr[p]) ? t.cr[p] : 5'($urandom);
            #1;
            chk("ac_valid", 64'(ac_valid_o), 64'(exp_acv));
            chk("cr_ready", 64'(cr_ready_o), 64'(exp_crr));
            chk("snoop_outs_idle", 64'({su_valid_o, mem_valid_o, req_ready_o}), 64'd0);
            for (int p = 0; p < N; p++)
                if (exp_acv[p]) chk("ac_payload", 64'(ac_o[p]), 64'(exp_ac));
            obs_acv_or = obs_acv_or | ac_valid_o;
            if (c == t.abort_at) begin
                #1 rst = 1'b1;
                #1;
                check_reset_values();
                @(negedge clk);
                rst = 1'b0;
                ac_ready = '0; cr_valid = '0;
                @(negedge clk);
                #1;
                chk("req_ready_after_rst", 64'(req_ready_o), 64'd1);
                chk("ac_valid_after_rst", 64'(ac_valid_o), 64'd0);
                return;
            end
            for (int p = 0; p < N; p++)
                if (hs[p]) hs_cyc[p] = c;
            acd = acd | hs;
            crd = crd | (crv & exp_crr);
            if ((crd & mask) == mask) begin
                done = 1;
            end else begin
                c++;
                @(negedge clk);
            end
        end

        @(negedge clk);
        ac_ready = t.noise ? 4'($urandom) : '0;
        cr_valid = t.noise ? 4'($urandom) : '0;
        #1;
        chk("decide_quiet", 64'({ac_valid_o, cr_ready_o, su_valid_o, mem_valid_o, req_ready_o}), 64'd0);

        k = 0;
        obs_out_cycles = 0;
        forever begin
            @(negedge clk);
            su_ready  = e_su  ? (k >= t.out_dly) : 1'($urandom);
            mem_ready = !e_su ? (k >= t.out_dly) : 1'($urandom);
            if (t.pend) begin
                req_valid = 1'b1;
                req_i = req_t'({$urandom, $urandom});
            end
            #1;
            obs_out_cycles++;
            chk("su_valid", 64'(su_valid_o), 64'(e_su));
            chk("mem_valid", 64'(mem_valid_o), 64'(!e_su));
            chk("out_req_ready", 64'(req_ready_o), 64'd0);
            chk("out_ac_valid", 64'(ac_valid_o), 64'd0);
            chk("summary", 64'({shared_o, dirty_o, da_o, fr_o}), 64'({e_sh, e_dr, e_da, e_fr}));
            chk("holder", 64'(holder_o), 64'(r));
            if (e_su) chk("su_op", 64'(su_op_o), 64'(e_op));
            obs_da = da_o; obs_fr = fr_o; obs_sh = shared_o; obs_dr = dirty_o;
            obs_op = su_op_o; obs_su = su_valid_o; obs_mem = mem_valid_o;
            if (k >= t.out_dly) break;
            k++;
        end
    endtask

    initial begin
        txn_t t;
        #2;
        check_reset_values();
        @(negedge clk);
        rst = 1'b0;

        // ReadShared, data from ports 2 and 3
        t = base_txn(0, 4'b0001);
        t.cr[1] = 5'b00000; t.cr[2] = 5'b01001; t.cr[3] = 5'b00001;
        run_txn(t);
        chk("tp1_su", 64'(obs_su), 64'd1);
        chk("tp1_op", 64'(obs_op), 64'd0);
        chk("tp1_da", 64'(obs_da), 64'b1100);
        chk("tp1_fr", 64'(obs_fr), 64'd2);
        chk("tp1_shared", 64'(obs_sh), 64'd1);
        chk("tp1_dirty", 64'(obs_dr), 64'd0);

        // Miss to memory, memory path stalls
        t = base_txn(0, 4'b0001);
        t.out_dly = 5;
        run_txn(t);
        chk("tp2_mem", 64'(obs_mem), 64'd1);
        chk("tp2_su", 64'(obs_su), 64'd0);
        chk("tp2_hold", 64'(obs_out_cycles), 64'd6);

        // MakeInvalid from port 2
        t = base_txn(2, 4'b1101);
        for (int p = 0; p < N; p++) t.cr[p] = 5'($urandom);
        run_txn(t);
        chk("tp3_op", 64'(obs_op), 64'd1);
        chk("tp3_no_ac2", 64'(obs_acv_or[2]), 64'd0);

        // Staggered AC readies with delayed CRs
        t = base_txn(2, 4'b0001);
        t.ac_dly[3] = 1; t.ac_dly[1] = 4; t.ac_dly[0] = 7;
        for (int p = 0; p < N; p++) t.cr_dly[p] = 2;
        t.cr[1] = 5'b00101;
        run_txn(t);
        chk("tp4_dirty", 64'(obs_dr), 64'd1);
        chk("tp4_fr", 64'(obs_fr), 64'd1);
        chk("tp4_da", 64'(obs_da), 64'b0010);

        // Snoop unit stalls while a second request waits
        t = base_txn(0, 4'b0001);
        t.cr[1] = 5'b00001; t.out_dly = 3; t.pend = 1;
        run_txn(t);
        t = base_txn(1, 4'b0000);
        t.cr[3] = 5'b10001;
        run_txn(t);
        chk("tp5_fr", 64'(obs_fr), 64'd3);

        // Reset while two AC are still outstanding, then a clean transaction
        t = base_txn(0, 4'b0001);
        t.ac_dly[2] = 10; t.ac_dly[3] = 10; t.abort_at = 2;
        run_txn(t);
        t = base_txn(0, 4'b0001);
        t.cr[1] = 5'b00001; t.cr[3] = 5'b01001;
        run_txn(t);
        chk("tp6_da", 64'(obs_da), 64'b1010);

        for (int n = 0; n < 200; n++) begin
            logic [3:0] snoops [6];
            snoops[0] = 4'b0000; snoops[1] = 4'b0001; snoops[2] = 4'b0111;
            snoops[3] = 4'b1001; snoops[4] = 4'b1101; snoops[5] = 4'b1011;
            t = base_txn($urandom_range(0, N - 1), snoops[$urandom_range(0, 5)]);
            t.addr = $urandom; t.prot = 3'($urandom); t.id = 4'($urandom);
            for (int p = 0; p < N; p++) begin
                t.cr[p]     = ($urandom_range(0, 2) == 0) ? 5'd0 : 5'($urandom);
                t.ac_dly[p] = $urandom_range(0, 4);
                t.cr_dly[p] = $urandom_range(0, 3);
            end
            t.out_dly = $urandom_range(0, 3);
            t.pend    = 1'($urandom);
            t.noise   = 1;
            t.abort_at = ($urandom_range(0, 19) == 0) ? $urandom_range(0, 3) : -1;
            run_txn(t);
        end

        @(negedge clk);
        req_valid = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
